alu_sequencer: RTL and testbench

Sequencing controller for the 8-bit combinational ALU (add, sub, AND, OR, XOR, NOT, shift-left, shift-right). Accepts one operation at a time over a valid/ready request channel and drives the ALU's A, B, carry-in and 3-bit select from registers. Iterates the ALU's single-bit shift to implement multi-bit shifts, then returns the registered result and a status flag over a valid/ready response channel. Sits between the instruction/test front end and the ALU datapath; it is the only agent allowed to drive the ALU inputs.

---
 rtl/alu_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: drives an external 8-bit combinational ALU one operation at a time,
// iterating its single-bit shift for multi-bit shifts. Optional feature macro: ALU_SEQ_CHAIN_EN.
module alu_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_cin,
    input  logic       req_chain,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    output logic       alu_cin,
    input  logic [7:0] alu_out,
    input  logic       alu_ovf,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_ovf
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;

    state_t     r_state;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [2:0] r_alu_sel;
    logic       r_alu_cin;
    logic [2:0] r_cnt;
    logic       r_sticky;
    logic [7:0] r_rsp_data;
    logic       r_rsp_ovf;
    logic       r_req_ready;
    logic       r_rsp_valid;

    logic [7:0] w_req_a_sel;
    logic       w_is_shift;
    logic       w_shift_bit;
    logic       w_rsp_fire;

    assign w_is_shift  = r_alu_sel[2] & r_alu_sel[1];
    // Bit leaving the register on this shift step: MSB for shl, LSB for shr.
    assign w_shift_bit = r_alu_sel[0] ? r_alu_a[0] : r_alu_a[7];
    assign w_rsp_fire  = r_rsp_valid & rsp_ready;

`ifdef ALU_SEQ_CHAIN_EN
    logic       r_chain;
    logic [7:0] r_last;

    // r_chain marks that a result has completed since reset; until then chained A is zero.
    assign w_req_a_sel = req_chain ? (r_chain ? r_last : 8'h00) : req_a;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= 1'b0;
            r_last  <= 8'h00;
        end else if (w_rsp_fire) begin
            r_chain <= 1'b1;
            r_last  <= r_rsp_data;
        end
    end
`else
    logic w_unused_chain;
    assign w_unused_chain = req_chain;
    assign w_req_a_sel    = req_a;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_alu_a     <= 8'h00;
            r_alu_b     <= 8'h00;
            r_alu_sel   <= 3'd0;
            r_alu_cin   <= 1'b0;
            r_cnt       <= 3'd0;
            r_sticky    <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_rsp_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_alu_a     <= w_req_a_sel;
                        r_alu_b     <= req_b;
                        r_alu_sel   <= req_op;
                        r_alu_cin   <= (req_op == OP_ADD) ? req_cin : 1'b0;
                        r_cnt       <= req_b[2:0];
                        r_sticky    <= 1'b0;
                        r_req_ready <= 1'b0;
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!w_is_shift) begin
                        r_rsp_data  <= alu_out;
                        r_rsp_ovf   <= (r_alu_sel == OP_ADD || r_alu_sel == OP_SUB) ? alu_ovf : 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_cnt == 3'd0) begin
                        r_rsp_data  <= r_alu_a;
                        r_rsp_ovf   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_alu_a    <= alu_out;
                        r_rsp_data <= alu_out;
                        r_sticky   <= r_sticky | w_shift_bit;
                        r_rsp_ovf  <= r_sticky | w_shift_bit;
                        r_cnt      <= r_cnt - 3'd1;
                        if (r_cnt == 3'd1) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_ovf   = r_rsp_ovf;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign alu_cin   = r_alu_cin;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU plus an arithmetic reference model of whole operations.
module tb_alu_sequencer;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = 3'd0;
    logic [7:0] req_a = 8'h00;
    logic [7:0] req_b = 8'h00;
    logic       req_cin = 1'b0;
    logic       req_chain = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic       alu_cin;
    logic [7:0] alu_out;
    logic       alu_ovf;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_ovf;

    int errors = 0;
    int checks = 0;

`ifdef ALU_SEQ_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic [7:0] m_last;
    logic [7:0] obs_data;
    logic       obs_ovf;
    logic [7:0] trace [0:31];

    alu_sequencer dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_chain(req_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ovf(rsp_ovf)
    );

    always #5 clock = ~clock;

    // ALU with single-bit shifts; flag is deliberately 1 where it carries no meaning.
    always_comb begin
        alu_out = 8'h00;
        alu_ovf = 1'b1;
        case (alu_sel)
            3'd0: {alu_ovf, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
            3'd1: begin alu_out = alu_a - alu_b; alu_ovf = (alu_a < alu_b); end
            3'd2: alu_out = alu_a & alu_b;
            3'd3: alu_out = alu_a | alu_b;
            3'd4: alu_out = alu_a ^ alu_b;
            3'd5: alu_out = ~alu_a;
            3'd6: alu_out = {alu_a[6:0], 1'b0};
            default: alu_out = {1'b0, alu_a[7:1]};
        endcase
    end

    function automatic void ref_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                      input logic cin, output logic [7:0] d, output logic o);
        int n;
        int s;
        n = int'(b[2:0]);
        o = 1'b0;
        case (op)
            3'd0: begin s = int'(a) + int'(b) + int'(cin); d = 8'(s); o = (s > 255); end
            3'd1: begin d = a - b; o = (a < b); end
            3'd2: d = a & b;
            3'd3: d = a | b;
            3'd4: d = a ^ b;
            3'd5: d = ~a;
            3'd6: begin d = 8'(a << n); o = (n != 0) && ((a >> (8 - n)) != 8'h00); end
            default: begin d = a >> n; o = (n != 0) && ((a & 8'((1 << n) - 1)) != 8'h00); end
        endcase
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic chain, input int bp);
        logic [7:0] ea;
        logic [7:0] ed;
        logic       eo;
        int k;
        int cyc;
        ea = (CHAIN_EN && chain) ? m_last : a;
        ref_model(op, ea, b, (op == 3'd0) ? cin : 1'b0, ed, eo);
        k = (op[2] && op[1] && b[2:0] != 3'd0) ? int'(b[2:0]) : 1;
        req_op = op; req_a = a; req_b = b; req_cin = cin; req_chain = chain;
        req_valid = 1'b1;
        cyc = 0;
        while (!req_ready && cyc < 20) begin @(posedge clock); #1; cyc++; end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_a = 8'($urandom); req_b = 8'($urandom); req_op = 3'($urandom);
        checks++;
        if (alu_a !== ea || alu_b !== b || alu_sel !== op || alu_cin !== ((op == 3'd0) ? cin : 1'b0)) begin
            errors++;
            $display("FAIL operands: a=%h b=%h sel=%0d cin=%b required a=%h b=%h sel=%0d cin=%b",
                     alu_a, alu_b, alu_sel, alu_cin, ea, b, op, (op == 3'd0) ? cin : 1'b0);
        end
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            trace[cyc] = alu_a;
            @(posedge clock); #1;
            cyc++;
        end
        checks++;
        if (cyc != k) begin
            errors++;
            $display("FAIL latency op=%0d: got %0d cycles required %0d", op, cyc, k);
        end
        checks++;
        if (rsp_data !== ed || rsp_ovf !== eo || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h: data=%h ovf=%b rdy=%b required data=%h ovf=%b rdy=0",
                     op, ea, b, rsp_data, rsp_ovf, req_ready, ed, eo);
        end
        for (int i = 0; i < bp; i++) begin
            @(posedge clock); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_ovf !== eo || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cycle %0d: vld=%b data=%h ovf=%b rdy=%b required 1 %h %b 0",
                         i, rsp_valid, rsp_data, rsp_ovf, req_ready, ed, eo);
            end
        end
        obs_data = rsp_data;
        obs_ovf  = rsp_ovf;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== ed) begin
            errors++;
            $display("FAIL handshake_exit: vld=%b rdy=%b data=%h required 0 1 %h", rsp_valid, req_ready, rsp_data, ed);
        end
        m_last = ed;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        m_last = 8'h00;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_ovf !== 1'b0 ||
            alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 3'd0 || alu_cin !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h ovf=%b a=%h b=%h sel=%0d cin=%b required 1 0 00 0 00 00 0 0",
                     req_ready, rsp_valid, rsp_data, rsp_ovf, alu_a, alu_b, alu_sel, alu_cin);
        end
    endtask

    task automatic test_async_reset();
        req_op = 3'd2; req_a = 8'hFF; req_b = 8'hFF; req_cin = 1'b1; req_chain = 1'b0;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF) begin
            errors++;
            $display("FAIL pre_reset_done: vld=%b data=%h required 1 ff", rsp_valid, rsp_data);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 8'h00 || alu_a !== 8'h00 || alu_sel !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: vld=%b rdy=%b data=%h a=%h sel=%0d required 0 1 00 00 0",
                     rsp_valid, req_ready, rsp_data, alu_a, alu_sel);
        end
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        m_last = 8'h00;
    endtask

    task automatic test_directed();
        do_op(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        checks++;
        if (obs_data !== 8'h00 || obs_ovf !== 1'b1) begin
            errors++; $display("FAIL add_ff_01: data=%h ovf=%b required 00 1", obs_data, obs_ovf);
        end
        do_op(3'd5, 8'h0F, 8'h00, 1'b1, 1'b0, 0);
        checks++;
        if (obs_data !== 8'hF0 || obs_ovf !== 1'b0) begin
            errors++; $display("FAIL not_0f: data=%h ovf=%b required f0 0", obs_data, obs_ovf);
        end
        do_op(3'd0, 8'h10, 8'h20, 1'b1, 1'b0, 0);
        checks++;
        if (obs_data !== 8'h31 || obs_ovf !== 1'b0) begin
            errors++; $display("FAIL add_cin: data=%h ovf=%b required 31 0", obs_data, obs_ovf);
        end
        do_op(3'd1, 8'h10, 8'h20, 1'b1, 1'b0, 0);
        checks++;
        if (obs_data !== 8'hF0 || obs_ovf !== 1'b1) begin
            errors++; $display("FAIL sub_borrow: data=%h ovf=%b required f0 1", obs_data, obs_ovf);
        end
    endtask

    task automatic test_shift();
        do_op(3'd6, 8'h81, 8'h03, 1'b0, 1'b0, 0);
        checks++;
        if (obs_data !== 8'h08 || obs_ovf !== 1'b1 || trace[0] !== 8'h81 || trace[1] !== 8'h02 || trace[2] !== 8'h04) begin
            errors++;
            $display("FAIL shl_81_3: data=%h ovf=%b trace=%h,%h,%h required 08 1 81,02,04",
                     obs_data, obs_ovf, trace[0], trace[1], trace[2]);
        end
        do_op(3'd7, 8'h80, 8'h00, 1'b0, 1'b0, 0);
        checks++;
        if (obs_data !== 8'h80 || obs_ovf !== 1'b0) begin
            errors++; $display("FAIL shr_count0: data=%h ovf=%b required 80 0", obs_data, obs_ovf);
        end
        do_op(3'd7, 8'h03, 8'hFA, 1'b1, 1'b0, 0);
        checks++;
        if (obs_data !== 8'h00 || obs_ovf !== 1'b1) begin
            errors++; $display("FAIL shr_03_2: data=%h ovf=%b required 00 1", obs_data, obs_ovf);
        end
    endtask

    task automatic test_backpressure();
        do_op(3'd4, 8'hAA, 8'h0F, 1'b0, 1'b0, 5);
        checks++;
        if (obs_data !== 8'hA5 || obs_ovf !== 1'b0) begin
            errors++; $display("FAIL xor_bp: data=%h ovf=%b required a5 0", obs_data, obs_ovf);
        end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        req_op = 3'd6; req_a = 8'h01; req_b = 8'h07; req_cin = 1'b0; req_chain = 1'b0;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (alu_a !== 8'h08 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_shift_progress: a=%h vld=%b required 08 0", alu_a, rsp_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_a !== 8'h00) begin
            errors++; $display("FAIL mid_shift_reset: rdy=%b vld=%b a=%h required 1 0 00", req_ready, rsp_valid, alu_a);
        end
        @(negedge clock); reset_n = 1'b1;
        m_last = 8'h00;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (rsp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL discarded_op: rsp_valid high for %0d cycles required 0", seen);
        end
        do_op(3'd0, 8'h02, 8'h03, 1'b0, 1'b0, 0);
        checks++;
        if (obs_data !== 8'h05 || obs_ovf !== 1'b0) begin
            errors++; $display("FAIL add_after_reset: data=%h ovf=%b required 05 0", obs_data, obs_ovf);
        end
    endtask

    task automatic test_chain();
        test_reset();
        do_op(3'd0, 8'h10, 8'h01, 1'b0, 1'b1, 0);
        checks++;
        if (obs_data !== (CHAIN_EN ? 8'h01 : 8'h11)) begin
            errors++; $display("FAIL chain_after_reset: data=%h required %h", obs_data, CHAIN_EN ? 8'h01 : 8'h11);
        end
        do_op(3'd3, 8'h30, 8'h03, 1'b0, 1'b0, 0);
        checks++;
        if (obs_data !== 8'h33 || obs_ovf !== 1'b0) begin
            errors++; $display("FAIL or_30_03: data=%h ovf=%b required 33 0", obs_data, obs_ovf);
        end
        do_op(3'd0, 8'h10, 8'h01, 1'b0, 1'b1, 1);
        checks++;
        if (obs_data !== (CHAIN_EN ? 8'h34 : 8'h11)) begin
            errors++; $display("FAIL chained_add: data=%h required %h", obs_data, CHAIN_EN ? 8'h34 : 8'h11);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
    endtask

    initial begin
        m_last = 8'h00;
        obs_data = 8'h00;
        obs_ovf = 1'b0;
        test_reset();
        test_async_reset();
        test_directed();
        test_shift();
        test_backpressure();
        test_reset_mid_shift();
        test_chain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
